// File: rtl/pe_operand_join.sv
// Operand join for a PE: two small FIFOs feed A/B to the FU, with an
// accumulate loopback that takes B from the registered FU result.
module pe_operand_join #(
  parameter int N_BITS = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_BITS-1:0] a_data_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [N_BITS-1:0] b_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic              loopback_i,
  input  logic [N_BITS-1:0] fb_data_i,
  input  logic              flush_i,
  input  logic              fu_ready_i,
  output logic [N_BITS-1:0] a_o,
  output logic [N_BITS-1:0] b_o,
  output logic              ops_valid_o,
  output logic [15:0]       pair_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [N_BITS-1:0] r_mem_a [DEPTH];
  logic [N_BITS-1:0] r_mem_b [DEPTH];
  logic [AW-1:0]     r_rp_a, r_wp_a;
  logic [AW-1:0]     r_rp_b, r_wp_b;
  logic [CW-1:0]     r_cnt_a, r_cnt_b;
  logic [15:0]       r_pair_cnt;

  logic w_need_b, w_valid, w_fire;
  logic w_push_a, w_push_b, w_pop_a, w_pop_b;

  // Ready looks only at registered occupancy, never at a same-cycle pop.
  assign a_ready_o = (r_cnt_a != FULL) && !flush_i;
  assign b_ready_o = (r_cnt_b != FULL) && !flush_i;
  assign w_push_a  = a_valid_i && a_ready_o;
  assign w_push_b  = b_valid_i && b_ready_o;

  assign w_need_b  = !loopback_i;
  assign w_valid   = (r_cnt_a != '0)
                  && (!w_need_b || (r_cnt_b != '0))
                  && !flush_i;
  assign w_fire    = w_valid && fu_ready_i;
  assign w_pop_a   = w_fire;
  assign w_pop_b   = w_fire && w_need_b;

  assign ops_valid_o = w_valid;
  assign pair_cnt_o  = r_pair_cnt;
  assign a_o = w_valid ? r_mem_a[r_rp_a] : '0;
  assign b_o = !w_valid  ? '0
             : loopback_i ? fb_data_i
             : r_mem_b[r_rp_b];

  always_ff @(posedge clk_i) begin
    if (w_push_a) r_mem_a[r_wp_a] <= a_data_i;
    if (w_push_b) r_mem_b[r_wp_b] <= b_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rp_a     <= '0;
      r_wp_a     <= '0;
      r_cnt_a    <= '0;
      r_rp_b     <= '0;
      r_wp_b     <= '0;
      r_cnt_b    <= '0;
      r_pair_cnt <= '0;
    end else if (flush_i) begin
      r_rp_a  <= '0;
      r_wp_a  <= '0;
      r_cnt_a <= '0;
      r_rp_b  <= '0;
      r_wp_b  <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_push_a) r_wp_a <= r_wp_a + AW'(1);
      if (w_pop_a)  r_rp_a <= r_rp_a + AW'(1);
      if (w_push_b) r_wp_b <= r_wp_b + AW'(1);
      if (w_pop_b)  r_rp_b <= r_rp_b + AW'(1);
      r_cnt_a <= r_cnt_a + CW'(w_push_a) - CW'(w_pop_a);
      r_cnt_b <= r_cnt_b + CW'(w_push_b) - CW'(w_pop_b);
      if (w_fire) r_pair_cnt <= r_pair_cnt + 16'd1;
    end
  end
endmodule
